md_unit: RTL and testbench

Multiply/divide unit for the E stage of the five-stage pipeline. It executes mult/multu/div/divu over a fixed multi-cycle latency and owns the HI/LO registers for mthi/mtlo/mfhi/mflo. It exports `start` and `busy`, which the hazard controller combines with the D-stage instruction class to stall any HI/LO-touching instruction behind an in-flight operation.

---
 rtl/md_unit.sv | 132 +++++++++++++
 tb/tb_md_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: fixed-latency mult/div with a pending
// result buffer, plus the architectural HI/LO registers and their move/read ops.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  E_MDU_op,
  input  logic [31:0] E_rs_value,
  input  logic [31:0] E_rt_value,
  output logic        start,
  output logic        busy,
  output logic [31:0] E_MDU_read_data,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;

  function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, prod;
    sa   = $signed({{32{a[31]}}, a});
    sb   = $signed({{32{b[31]}}, b});
    prod = sa * sb;
    return prod;
  endfunction

  function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {remainder, quotient}; callers filter out a zero divisor.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  // Divide on magnitudes so 0x80000000 / -1 cannot overflow, then fix signs.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    logic [63:0] rq;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    rq = div_unsigned(ma, mb);
    q  = (a[31] ^ b[31]) ? -rq[31:0] : rq[31:0];
    r  = a[31] ? -rq[63:32] : rq[63:32];
    return {r, q};
  endfunction

  assign busy = (cnt_q != 4'd0);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    logic [63:0] res;
    start           = 1'b0;
    E_MDU_read_data = 32'd0;
    cnt_d           = cnt_q;
    hi_d            = hi_q;
    lo_d            = lo_q;
    p_hi_d          = p_hi_q;
    p_lo_d          = p_lo_q;
    res             = 64'd0;

    if (E_MDU_op == OP_MFHI) E_MDU_read_data = hi_q;
    else if (E_MDU_op == OP_MFLO) E_MDU_read_data = lo_q;

    if (busy) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = p_hi_q;
        lo_d = p_lo_q;
      end
    end else begin
      case (E_MDU_op)
        OP_MULT, OP_MULTU: begin
          start  = 1'b1;
          res    = (E_MDU_op == OP_MULT) ? mul_signed(E_rs_value, E_rt_value)
                                         : mul_unsigned(E_rs_value, E_rt_value);
          p_hi_d = res[63:32];
          p_lo_d = res[31:0];
          cnt_d  = 4'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          start = 1'b1;
          cnt_d = 4'(DIV_CYCLES);
          // A zero divisor commits the current HI/LO, leaving them unchanged.
          if (E_rt_value == 32'd0) begin
            p_hi_d = hi_q;
            p_lo_d = lo_q;
          end else begin
            res    = (E_MDU_op == OP_DIV) ? div_signed(E_rs_value, E_rt_value)
                                          : div_unsigned(E_rs_value, E_rt_value);
            p_hi_d = res[63:32];
            p_lo_d = res[31:0];
          end
        end
        OP_MTHI: hi_d = E_rs_value;
        OP_MTLO: lo_d = E_rs_value;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 4'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      p_hi_q <= 32'd0;
      p_lo_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      p_hi_q <= p_hi_d;
      p_lo_q <= p_lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, hand-written corner sequences and
// randomized ops checked against a plain-arithmetic HI/LO model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  E_MDU_op;
  logic [31:0] E_rs_value, E_rt_value;
  logic        start, busy;
  logic [31:0] E_MDU_read_data, HI, LO;

  int passed = 0;
  int total  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .E_MDU_op(E_MDU_op),
    .E_rs_value(E_rs_value), .E_rt_value(E_rt_value),
    .start(start), .busy(busy), .E_MDU_read_data(E_MDU_read_data),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt, hi, lo;
    int          n;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int op_cycles(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return 5;
    if (op == 4'd3 || op == 4'd4) return 10;
    return 0;
  endfunction

  // Reference: architectural {HI,LO} after op completes, from plain arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return {m_hi, m_lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {m_hi, m_lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      4'd5: return {a, m_lo};
      4'd6: return {m_hi, a};
      default: return {m_hi, m_lo};
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] ehi, input logic [31:0] elo, input int n);
    int   cnt;
    logic hold_ok;
    cnt     = 0;
    hold_ok = 1'b1;
    @(negedge clk);
    E_MDU_op = op; E_rs_value = rs; E_rt_value = rt;
    #1 chk("start", 32'(start), 32'(n != 0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      E_MDU_op = 4'd0; E_rs_value = $urandom; E_rt_value = $urandom;
      #1;
      if (!busy) break;
      cnt++;
      if (HI !== m_hi || LO !== m_lo) hold_ok = 1'b0;
    end
    chk("busy_cycles", 32'(cnt), 32'(n));
    if (n != 0) chk("hilo_held_while_busy", 32'(hold_ok), 32'd1);
    chk("HI", HI, ehi);
    chk("LO", LO, elo);
    m_hi = ehi;
    m_lo = elo;
    @(negedge clk); E_MDU_op = 4'd7;
    #1 chk("mfhi", E_MDU_read_data, ehi);
    @(negedge clk); E_MDU_op = 4'd8;
    #1 chk("mflo", E_MDU_read_data, elo);
    @(negedge clk); E_MDU_op = 4'd0;
  endtask

  vec_t vt[10];

  initial begin
    logic [63:0] e;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    vt[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vt[1] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, 5};
    vt[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 32'h80000000, 10};
    vt[4] = '{4'd4, 32'd100,      32'd7,          32'h00000002, 32'h0000000E, 10};
    vt[5] = '{4'd5, 32'h11,       32'd0,          32'h00000011, 32'h0000000E, 0};
    vt[6] = '{4'd6, 32'h22,       32'd0,          32'h00000011, 32'h00000022, 0};
    vt[7] = '{4'd4, 32'd12345,    32'd0,          32'h00000011, 32'h00000022, 10};
    vt[8] = '{4'd3, 32'hFFFFFFF9, 32'd0,          32'h00000011, 32'h00000022, 10};
    vt[9] = '{4'd1, 32'd7,        32'hFFFFFFFA,   32'hFFFFFFFF, 32'hFFFFFFD6, 5};

    rst_n = 1'b0; E_MDU_op = 4'd0; E_rs_value = 32'd0; E_rt_value = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_rdata", E_MDU_read_data, 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(vt[i].op, vt[i].rs, vt[i].rt, vt[i].hi, vt[i].lo, vt[i].n);

    // Ops issued while busy are dropped; only MULT 2x3 lands.
    @(negedge clk); E_MDU_op = 4'd1; E_rs_value = 32'd2; E_rt_value = 32'd3;
    @(negedge clk); E_MDU_op = 4'd6; E_rs_value = 32'h1234;
    @(negedge clk); E_MDU_op = 4'd1; E_rs_value = 32'd9; E_rt_value = 32'd9;
    #1 chk("start_while_busy", 32'(start), 32'd0);
    @(negedge clk); E_MDU_op = 4'd5; E_rs_value = 32'hDEAD;
    @(negedge clk); E_MDU_op = 4'd0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    #1;
    chk("busy_drop_HI", HI, 32'd0);
    chk("busy_drop_LO", LO, 32'd6);
    m_hi = 32'd0; m_lo = 32'd6;

    // Back-to-back: the cycle busy drops accepts a new start.
    @(negedge clk); E_MDU_op = 4'd2; E_rs_value = 32'd3; E_rt_value = 32'd4;
    for (int i = 0; i < 5; i++) begin @(negedge clk); E_MDU_op = 4'd0; end
    @(negedge clk); E_MDU_op = 4'd2; E_rs_value = 32'd5; E_rt_value = 32'd6;
    #1 chk("b2b_start", 32'(start), 32'd1);
    chk("b2b_first_LO", LO, 32'd12);
    @(negedge clk); E_MDU_op = 4'd0;
    #1 chk("b2b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    #1 chk("b2b_second_LO", LO, 32'd30);
    m_hi = 32'd0; m_lo = 32'd30;

    // Mid-operation asynchronous reset in busy cycle 4.
    run_op(4'd5, 32'h55, 32'd0, 32'h55, 32'd30, 0);
    @(negedge clk); E_MDU_op = 4'd3; E_rs_value = 32'd100; E_rt_value = 32'd7;
    for (int i = 0; i < 3; i++) begin @(negedge clk); E_MDU_op = 4'd0; end
    #1 chk("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_HI", HI, 32'd0);
    chk("async_rst_LO", LO, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    run_op(4'd1, 32'd4, 32'd5, 32'd0, 32'd20, 5);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 17));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      e = model(rop, ra, rb);
      run_op(rop, ra, rb, e[63:32], e[31:0], op_cycles(rop));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
